// File: rtl/fib_req_sched.sv
// Round-robin request scheduler in front of a FIB lookup engine.
// Per-port outstanding counters throttle each port to max_out lookups in flight;
// a single holding register presents one request at a time to the FIB.
module fib_req_sched #(
  parameter int unsigned width   = 64,
  parameter int unsigned inputs  = 4,
  parameter int unsigned max_out = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [inputs-1:0]       c_srdy,
  output logic [inputs-1:0]       c_drdy,
  input  logic [inputs*width-1:0] c_data,
  output logic                    p_srdy,
  input  logic                    p_drdy,
  output logic [width-1:0]        p_data,
  output logic [2:0]              p_port,
  input  logic [inputs-1:0]       r_done,
  output logic                    err_underflow
);

  localparam int unsigned PW = (inputs > 1) ? $clog2(inputs) : 1;

  typedef enum logic {StEmpty, StFull} state_e;

  state_e                 state_q, state_d;
  logic [width-1:0]       data_q, data_d;
  logic [2:0]             port_q, port_d;
  logic [PW-1:0]          last_q, last_d;
  logic [inputs-1:0][2:0] cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic [inputs-1:0]      eligible;
  logic [inputs-1:0]      grant;
  logic                   gnt_ok, gnt_any, gnt;
  logic [PW-1:0]          gnt_idx;

  // A port may be served only while it has lookup credit left.
  always_comb begin
    eligible = '0;
    for (int k = 0; k < inputs; k++) begin
      eligible[k] = c_srdy[k] && (cnt_q[k] < 3'(max_out));
    end
  end

  // Round-robin pick starting one past the last granted port; never looks at c_data.
  always_comb begin
    int unsigned   cand;
    logic [PW-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    grant    = '0;
    gnt_ok   = !reset && ((state_q == StEmpty) || p_drdy);
    for (int unsigned i = 1; i <= inputs; i++) begin
      cand     = (32'(last_q) + i) % inputs;
      cand_idx = PW'(cand);
      if (!gnt_any && eligible[cand_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx;
      end
    end
    gnt = gnt_ok && gnt_any;
    if (gnt) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  // Output-stage, arbitration pointer and credit-counter next state.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    port_d  = port_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (gnt) begin
      state_d = StFull;
      data_d  = c_data[32'(gnt_idx) * width +: width];
      port_d  = 3'(gnt_idx);
      last_d  = gnt_idx;
    end else if ((state_q == StFull) && p_drdy) begin
      state_d = StEmpty;
    end
    for (int k = 0; k < inputs; k++) begin
      // Simultaneous grant and completion cancel out.
      if (grant[k] && !r_done[k]) begin
        cnt_d[k] = cnt_q[k] + 3'd1;
      end else if (!grant[k] && r_done[k]) begin
        if (cnt_q[k] == 3'd0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] - 3'd1;
        end
      end
    end
  end

  // All state, including registered outputs; reset clears everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StEmpty;
      data_q  <= '0;
      port_q  <= '0;
      last_q  <= PW'(inputs - 1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      port_q  <= port_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign c_drdy        = grant;
  assign p_srdy        = (state_q == StFull);
  assign p_data        = data_q;
  assign p_port        = port_q;
  assign err_underflow = err_q;

endmodule

// File: doc/fib_req_sched.md
FIB_REQ_SCHED -- requirements
Module: fib_req_sched

Interface
REQ-001 Parameter: width, default 64, bits per request word.
REQ-002 Parameter: inputs, default 4, number of requesting ports.
REQ-003 Parameter: max_out, default 2, maximum outstanding FIB lookups per port (range 1..7).
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 c_srdy  input  inputs  per-port request valid.
REQ-007 c_drdy  output  inputs  per-port request accept; at most one bit set per cycle.
REQ-008 c_data  input  inputs*width  request words; port k occupies bits [k*width +: width].
REQ-009 p_srdy  output  1  request valid toward the FIB.
REQ-010 p_drdy  input  1  FIB accepts request.
REQ-011 p_data  output  width  registered request word.
REQ-012 p_port  output  3  index of the port that owns p_data.
REQ-013 r_done  input  inputs  per-port one-cycle pulse marking completion of that port's lookup result.
REQ-014 err_underflow  output  1  sticky flag: r_done received for a port with zero outstanding.

Function
REQ-015 Output stage: single holding register (p_data, p_port, p_srdy); states EMPTY (p_srdy=0) and FULL (p_srdy=1).
REQ-016 Port k eligible when c_srdy[k]=1 and outstanding[k] < max_out.
REQ-017 Grant allowed in a cycle when state is EMPTY, or state is FULL with p_drdy=1 (back-to-back, one request per cycle sustained).
REQ-018 Round-robin selection: search starts at (last_grant+1) mod inputs; first eligible port wins; last_grant updates only on a grant.
REQ-019 On grant to k: c_drdy[k]=1 combinationally in the same cycle; next cycle p_data=c_data[k], p_port=k, p_srdy=1.
REQ-020 c_drdy[k] depends only on state, p_drdy, c_srdy and the counters; it never depends on c_data.
REQ-021 FULL with p_drdy=0: p_data/p_port held stable, no grant, all c_drdy=0.
REQ-022 FULL with p_drdy=1 and no grant: next state EMPTY.
REQ-023 No eligible port: no grant, all c_drdy=0.
REQ-024 outstanding[k] (3 bits) increments on grant to k.
REQ-025 outstanding[k] decrements on r_done[k].
REQ-026 Grant to k and r_done[k] in the same cycle: outstanding[k] unchanged.
REQ-027 r_done[k] with outstanding[k]=0 and no grant to k: counter stays 0; err_underflow sets.
REQ-028 Counter never exceeds max_out; a port at max_out becomes eligible again in the cycle after its r_done.
REQ-029 Latency c_srdy→p_srdy: 1 cycle when eligible and the output stage is free.

Reset
REQ-030 While reset=1: p_srdy=0, p_data=0, p_port=0, c_drdy=0, all outstanding=0, last_grant=inputs-1 (port 0 searched first), err_underflow=0.
REQ-031 Reset asserted mid-transfer discards the held request; no partial state survives reset.
REQ-032 First grant possible on the first rising edge after reset deasserts.

Verification
REQ-033 All four c_srdy=1, p_drdy=1, r_done pulsed on each acceptance -> p_port sequence 0,1,2,3,0, one per cycle.
REQ-034 Only port 2 requests, p_drdy=1, no r_done -> exactly 2 grants to port 2; c_drdy[2]=0 thereafter; one r_done[2] -> a third grant the next cycle.
REQ-035 p_srdy=1, p_drdy held 0 for 5 cycles with c_data changing -> p_data/p_port constant and c_drdy=0 throughout; p_drdy=1 -> transfer, with a new grant that same cycle.
REQ-036 Grant to port 1 coincident with r_done[1] while outstanding[1]=1 -> outstanding[1] stays 1.
REQ-037 r_done[3] with outstanding[3]=0 -> err_underflow=1 and stays 1 until reset.
REQ-038 Reset asserted while FULL -> p_srdy=0 immediately (asynchronous); after release with ports 0 and 3 requesting -> port 0 granted first.
